// File: rtl/alu_sched_pkg.sv
// Shared types for the two-requester ALU scheduler: opcode classes, ALU op
// encoding, scheduler states and the R-type funct decode.
package alu_sched_pkg;

   localparam logic [6:0] R_TYPE    = 7'b0110011;
   localparam logic [6:0] I_TYPE_LD = 7'b0000011;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SLL  = 4'd2,
      OP_SLT  = 4'd3,
      OP_SLTU = 4'd4,
      OP_XOR  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_OR   = 4'd8,
      OP_AND  = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ALU_RQ = 2'd1,
      ALU_RL = 2'd2,
      CL_ACK = 2'd3
   } sched_state_e;

   function automatic alu_op_e decode_r(input logic [2:0] funct3, input logic f7b5);
      alu_op_e op;
      case (funct3)
         3'b000:  op = f7b5 ? OP_SUB : OP_ADD;
         3'b001:  op = OP_SLL;
         3'b010:  op = OP_SLT;
         3'b011:  op = OP_SLTU;
         3'b100:  op = OP_XOR;
         3'b101:  op = f7b5 ? OP_SRA : OP_SRL;
         3'b110:  op = OP_OR;
         default: op = OP_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_sched_rr_arb.sv
// Two-way round-robin grant: a single eligible side wins outright, a tie goes
// to the side that did not own the ALU last.
module alu_sched_rr_arb
   import alu_sched_pkg::*;
(
   input  logic elig_ld,
   input  logic elig_r,
   input  logic last_owner,
   output logic gnt,
   output logic gnt_owner
);

   always_comb begin
      gnt       = elig_ld | elig_r;
      gnt_owner = 1'b0;
      if (elig_ld && elig_r) begin
         gnt_owner = ~last_owner;
      end else if (elig_r) begin
         gnt_owner = 1'b1;
      end
   end

endmodule

// File: rtl/alu_share_sched.sv
// Shares one ALU between the load address path (owner 0) and the R-type path
// (owner 1) using 4-phase handshakes on both sides and toward the ALU.
module alu_share_sched
   import alu_sched_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_ld_i,
   input  logic [6:0]      opcode_ld_i,
   input  logic [XLEN-1:0] rs1_ld_i,
   input  logic [XLEN-1:0] imm_ld_i,
   output logic            ack_ld_o,
   output logic [XLEN-1:0] res_ld_o,
   input  logic            req_r_i,
   input  logic [6:0]      opcode_r_i,
   input  logic [2:0]      funct3_r_i,
   input  logic            f7b5_r_i,
   input  logic [XLEN-1:0] rs1_r_i,
   input  logic [XLEN-1:0] rs2_r_i,
   output logic            ack_r_o,
   output logic [XLEN-1:0] res_r_o,
   output logic            alu_req_o,
   output logic [3:0]      alu_op_o,
   output logic [XLEN-1:0] alu_a_o,
   output logic [XLEN-1:0] alu_b_o,
   input  logic            alu_ack_i,
   input  logic [XLEN-1:0] alu_res_i,
   output logic            owner_o,
   output logic            busy_o,
   output logic            err_o
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
   localparam logic             WD_ON  = (TIMEOUT != 0);

   sched_state_e    state;
   logic [CNT_W-1:0] wd_cnt;
   logic [XLEN-1:0]  res_q;
   logic             gnt;
   logic             gnt_owner;
   logic             owner_req;
   logic             wd_hung;

   alu_sched_rr_arb u_arb (
      .elig_ld    (req_ld_i & ~ack_ld_o),
      .elig_r     (req_r_i & ~ack_r_o),
      .last_owner (owner_o),
      .gnt        (gnt),
      .gnt_owner  (gnt_owner)
   );

   assign owner_req = owner_o ? req_r_i : req_ld_i;
   // Once the watchdog fires the handshake is frozen until reset.
   assign wd_hung   = WD_ON && (wd_cnt == TO_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ack_ld_o  <= 1'b0;
         ack_r_o   <= 1'b0;
         alu_req_o <= 1'b0;
         busy_o    <= 1'b0;
         err_o     <= 1'b0;
         owner_o   <= 1'b1;
         alu_op_o  <= OP_ADD;
         alu_a_o   <= '0;
         alu_b_o   <= '0;
         res_ld_o  <= '0;
         res_r_o   <= '0;
         res_q     <= '0;
         wd_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               // A stale ALU ack blocks any new grant.
               if (gnt && !alu_ack_i) begin
                  owner_o   <= gnt_owner;
                  alu_req_o <= 1'b1;
                  busy_o    <= 1'b1;
                  wd_cnt    <= '0;
                  state     <= ALU_RQ;
                  if (!gnt_owner) begin
                     alu_op_o <= OP_ADD;
                     alu_a_o  <= rs1_ld_i;
                     alu_b_o  <= imm_ld_i;
                     if (opcode_ld_i != I_TYPE_LD) err_o <= 1'b1;
                  end else begin
                     alu_a_o <= rs1_r_i;
                     alu_b_o <= rs2_r_i;
                     if (opcode_r_i != R_TYPE) begin
                        err_o    <= 1'b1;
                        alu_op_o <= OP_ADD;
                     end else begin
                        alu_op_o <= decode_r(funct3_r_i, f7b5_r_i);
                     end
                  end
               end
            end
            ALU_RQ: begin
               if (!owner_req) err_o <= 1'b1;
               if (!wd_hung) begin
                  if (alu_ack_i) begin
                     res_q     <= alu_res_i;
                     alu_req_o <= 1'b0;
                     wd_cnt    <= '0;
                     state     <= ALU_RL;
                  end else if (WD_ON) begin
                     wd_cnt <= wd_cnt + 1'b1;
                     if (wd_cnt == TO_CNT - 1'b1) err_o <= 1'b1;
                  end
               end
            end
            ALU_RL: begin
               if (!owner_req) err_o <= 1'b1;
               if (!wd_hung) begin
                  if (!alu_ack_i) begin
                     if (owner_o) begin
                        res_r_o <= res_q;
                        ack_r_o <= 1'b1;
                     end else begin
                        res_ld_o <= res_q;
                        ack_ld_o <= 1'b1;
                     end
                     state <= CL_ACK;
                  end else if (WD_ON) begin
                     wd_cnt <= wd_cnt + 1'b1;
                     if (wd_cnt == TO_CNT - 1'b1) err_o <= 1'b1;
                  end
               end
            end
            CL_ACK: begin
               if (!owner_req) begin
                  ack_ld_o <= 1'b0;
                  ack_r_o  <= 1'b0;
                  busy_o   <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_sched.sv
// Directed bench for alu_share_sched with a behavioural ALU that can ack
// immediately, never ack, or hold a stuck ack.
module tb_alu_share_sched;
   import alu_sched_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_ld;
   logic [6:0]      opcode_ld;
   logic [XLEN-1:0] rs1_ld, imm_ld;
   logic            ack_ld;
   logic [XLEN-1:0] res_ld;
   logic            req_r;
   logic [6:0]      opcode_r;
   logic [2:0]      funct3_r;
   logic            f7b5_r;
   logic [XLEN-1:0] rs1_r, rs2_r;
   logic            ack_r;
   logic [XLEN-1:0] res_r;
   logic            alu_req;
   logic [3:0]      alu_op;
   logic [XLEN-1:0] alu_a, alu_b;
   logic            alu_ack;
   logic [XLEN-1:0] alu_res;
   logic            owner, busy, err;

   logic alu_en;
   logic force_ack;

   int errors = 0;
   int checks = 0;

   int              seq_n;
   logic            seq_who [0:3];
   logic [XLEN-1:0] got_ld, got_r;

   always #5 clk = ~clk;

   alu_share_sched #(.XLEN(XLEN), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .req_ld_i(req_ld), .opcode_ld_i(opcode_ld), .rs1_ld_i(rs1_ld), .imm_ld_i(imm_ld),
      .ack_ld_o(ack_ld), .res_ld_o(res_ld),
      .req_r_i(req_r), .opcode_r_i(opcode_r), .funct3_r_i(funct3_r), .f7b5_r_i(f7b5_r),
      .rs1_r_i(rs1_r), .rs2_r_i(rs2_r), .ack_r_o(ack_r), .res_r_o(res_r),
      .alu_req_o(alu_req), .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
      .alu_ack_i(alu_ack), .alu_res_i(alu_res),
      .owner_o(owner), .busy_o(busy), .err_o(err)
   );

   function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a << b[4:0];
         4'd3:    return {31'd0, $signed(a) < $signed(b)};
         4'd4:    return {31'd0, a < b};
         4'd5:    return a ^ b;
         4'd6:    return a >> b[4:0];
         4'd7:    return $signed(a) >>> b[4:0];
         4'd8:    return a | b;
         4'd9:    return a & b;
         default: return '0;
      endcase
   endfunction

   // Combinational ALU: ack follows req in the same cycle.
   assign alu_ack = force_ack | (alu_en & alu_req);
   assign alu_res = alu_fn(alu_op, alu_a, alu_b);

   task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Acts as both requesters: drops each req once its ack is seen, records order.
   task automatic serve(input int maxc, input string tag);
      logic done;
      done  = 1'b0;
      seq_n = 0;
      for (int i = 0; i < maxc && !done; i++) begin
         tick();
         if (req_ld && ack_ld) begin
            check({tag, "_own_ld"}, XLEN'(owner), 0);
            if (seq_n < 4) seq_who[seq_n] = 1'b0;
            seq_n++;
            got_ld = res_ld;
            req_ld = 1'b0;
         end
         if (req_r && ack_r) begin
            check({tag, "_own_r"}, XLEN'(owner), 1);
            if (seq_n < 4) seq_who[seq_n] = 1'b1;
            seq_n++;
            got_r = res_r;
            req_r = 1'b0;
         end
         if (!req_ld && !req_r && !ack_ld && !ack_r && !busy) done = 1'b1;
      end
      check({tag, "_done"}, XLEN'(done), 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ack_ld"}, XLEN'(ack_ld), 0);
      check({tag, "_ack_r"}, XLEN'(ack_r), 0);
      check({tag, "_alu_req"}, XLEN'(alu_req), 0);
      check({tag, "_busy"}, XLEN'(busy), 0);
      check({tag, "_err"}, XLEN'(err), 0);
      check({tag, "_owner"}, XLEN'(owner), 1);
      check({tag, "_op"}, XLEN'(alu_op), 0);
      check({tag, "_a"}, alu_a, 0);
      check({tag, "_b"}, alu_b, 0);
      check({tag, "_res_ld"}, res_ld, 0);
      check({tag, "_res_r"}, res_r, 0);
   endtask

   initial begin
      rst = 1'b1; req_ld = 1'b0; req_r = 1'b0;
      opcode_ld = I_TYPE_LD; rs1_ld = '0; imm_ld = '0;
      opcode_r = R_TYPE; funct3_r = 3'd0; f7b5_r = 1'b0; rs1_r = '0; rs2_r = '0;
      alu_en = 1'b1; force_ack = 1'b0;
      got_ld = '0; got_r = '0;

      // Reset state and single LD latency
      tick(); tick();
      check_reset_outputs("rst0");
      rst = 1'b0;
      tick();
      req_ld = 1'b1; rs1_ld = 32'h1000; imm_ld = 32'h10;
      tick();
      check("t1_op", XLEN'(alu_op), 0);
      check("t1_a", alu_a, 32'h1000);
      check("t1_b", alu_b, 32'h10);
      check("t1_owner", XLEN'(owner), 0);
      check("t1_busy", XLEN'(busy), 1);
      check("t1_ack_c1", XLEN'(ack_ld), 0);
      tick();
      check("t1_ack_c2", XLEN'(ack_ld), 0);
      tick();
      check("t1_ack_c3", XLEN'(ack_ld), 1);
      check("t1_res", res_ld, 32'h1010);
      req_ld = 1'b0;
      tick();
      check("t1_ack_fall", XLEN'(ack_ld), 0);
      check("t1_idle", XLEN'(busy), 0);
      tick();
      check("t1_res_hold", res_ld, 32'h1010);

      // Simultaneous requests from reset: LD first, then R
      do_reset();
      req_ld = 1'b1; rs1_ld = 32'h40; imm_ld = 32'h4;
      req_r = 1'b1; opcode_r = R_TYPE; funct3_r = 3'b000; f7b5_r = 1'b1;
      rs1_r = 32'd7; rs2_r = 32'd5;
      serve(40, "t2a");
      check("t2a_n", XLEN'(seq_n), 2);
      check("t2a_first", XLEN'(seq_who[0]), 0);
      check("t2a_second", XLEN'(seq_who[1]), 1);
      check("t2a_res_ld", got_ld, 32'h44);
      check("t2a_res_r", got_r, 32'd2);

      // Solo LD leaves owner=0, so the next tie goes to R
      req_ld = 1'b1; rs1_ld = 32'd1; imm_ld = 32'd1;
      serve(20, "t2s");
      check("t2s_res_ld", got_ld, 32'd2);
      req_ld = 1'b1; rs1_ld = 32'h100; imm_ld = 32'h20;
      req_r = 1'b1; funct3_r = 3'b100; f7b5_r = 1'b0; rs1_r = 32'hF0; rs2_r = 32'hFF;
      serve(40, "t2b");
      check("t2b_n", XLEN'(seq_n), 2);
      check("t2b_first", XLEN'(seq_who[0]), 1);
      check("t2b_second", XLEN'(seq_who[1]), 0);
      check("t2b_res_r", got_r, 32'h0F);
      check("t2b_res_ld", got_ld, 32'h120);

      // SRA of a negative value
      req_r = 1'b1; funct3_r = 3'b101; f7b5_r = 1'b1; rs1_r = 32'h8000_0000; rs2_r = 32'd4;
      tick();
      check("t3_op", XLEN'(alu_op), 7);
      check("t3_a", alu_a, 32'h8000_0000);
      serve(20, "t3");
      check("t3_res", got_r, 32'hF800_0000);
      check("t3_err", XLEN'(err), 0);

      // Wrong opcode class on R: error flagged, runs as ADD
      req_r = 1'b1; opcode_r = I_TYPE_LD; funct3_r = 3'b000; f7b5_r = 1'b1;
      rs1_r = 32'd3; rs2_r = 32'd4;
      tick();
      check("t4_err", XLEN'(err), 1);
      check("t4_op", XLEN'(alu_op), 0);
      serve(20, "t4");
      check("t4_n", XLEN'(seq_n), 1);
      check("t4_res", got_r, 32'd7);
      check("t4_err_sticky", XLEN'(err), 1);
      opcode_r = R_TYPE;

      // Watchdog: ALU never acks
      do_reset();
      check("t5_err_clr", XLEN'(err), 0);
      alu_en = 1'b0;
      req_ld = 1'b1; rs1_ld = 32'h5; imm_ld = 32'h6;
      tick();
      check("t5_req", XLEN'(alu_req), 1);
      repeat (7) tick();
      check("t5_err_c7", XLEN'(err), 0);
      tick();
      check("t5_err_c8", XLEN'(err), 1);
      alu_en = 1'b1;
      repeat (4) tick();
      check("t5_no_ack", XLEN'(ack_ld), 0);
      check("t5_held_req", XLEN'(alu_req), 1);
      check("t5_held_busy", XLEN'(busy), 1);
      req_ld = 1'b0; rst = 1'b1;
      tick();
      check_reset_outputs("t5_rst");
      rst = 1'b0;

      // Stale ALU ack across reset blocks the grant
      force_ack = 1'b1;
      do_reset();
      req_ld = 1'b1; rs1_ld = 32'h200; imm_ld = 32'hFFFF_FFF0;
      repeat (3) tick();
      check("t6_no_gnt_busy", XLEN'(busy), 0);
      check("t6_no_gnt_req", XLEN'(alu_req), 0);
      force_ack = 1'b0;
      serve(20, "t6");
      check("t6_n", XLEN'(seq_n), 1);
      check("t6_res", got_ld, 32'h1F0);
      check("t6_err", XLEN'(err), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
